gshare_bpu: RTL and testbench
=============================

GSHARE_BPU -- requirements
Module: gshare_bpu

Interface
REQ-001 Parameter BHT_IDX_W, default 8; BHT holds 2^BHT_IDX_W 2-bit counters.
REQ-002 Parameter GHR_W, default 8, legal 0..BHT_IDX_W; global history length.
REQ-003 Parameter BTB_IDX_W, default 6; BTB holds 2^BTB_IDX_W direct-mapped entries.
REQ-004 Parameter MODE, default 1; 0 = bimodal (PC index only), 1 = gshare (PC XOR history).
REQ-005 Port clk  in  1  sole clock, rising edge.
REQ-006 Port rst  in  1  reset, asynchronous, active-high.
REQ-007 Port lookup_PC  in  32  fetch-stage PC to predict.
REQ-008 Port predict_taken  out  1  counter MSB for lookup_PC; combinational.
REQ-009 Port BTB_hit  out  1  valid entry with matching tag for lookup_PC; combinational.
REQ-010 Port BTB_PC  out  32  stored target for lookup_PC; 0 when BTB_hit=0.
REQ-011 Port lookup_ghr  out  GHR_W (min 1)  history snapshot used for this lookup; pipeline carries it to resolution.
REQ-012 Port updata_enable  in  1  a conditional branch resolved this cycle.
REQ-013 Port updata_PC  in  32  PC of resolved branch.
REQ-014 Port updata_ghr  in  GHR_W (min 1)  lookup_ghr value carried with the resolved branch.
REQ-015 Port updata_taken  in  1  actual direction.
REQ-016 Port updata_miss  in  1  resolved branch was mispredicted (qualified by updata_enable).
REQ-017 Port destination_PC  in  32  actual taken target.
REQ-018 Port branch_count  out  32  resolved-branch counter.
REQ-019 Port branch_miss_count  out  32  misprediction counter.

Function
REQ-020 Lookup index SHALL be lookup_PC[BHT_IDX_W+1:2] in MODE 0; in MODE 1 the same field XOR {zero-extended GHR}.
REQ-021 Update index SHALL use updata_PC and updata_ghr with the same rule, never the live GHR.
REQ-022 Counters SHALL be 2-bit saturating: taken increments, stopping at 11; not-taken decrements, stopping at 00.
REQ-023 Counter write SHALL occur on the clk edge where updata_enable=1; no write otherwise.
REQ-024 GHR SHALL shift left, inserting updata_taken at bit 0, on each updata_enable edge; GHR_W=0 keeps it constant 0.
REQ-025 In MODE 0 the GHR SHALL still update, but it SHALL NOT affect indexing.
REQ-026 BTB entry = valid, tag lookup_PC[31:BTB_IDX_W+2], 32-bit target; index PC[BTB_IDX_W+1:2].
REQ-027 BTB SHALL write (valid=1, tag, destination_PC) only when updata_enable=1 and updata_taken=1; a not-taken resolution SHALL leave the BTB unchanged.
REQ-028 A tag conflict SHALL overwrite the resident entry (no replacement policy).
REQ-029 Same-cycle lookup and update to the same index SHALL return the pre-update value; the new value SHALL be visible the next cycle.
REQ-030 branch_count SHALL increment on each updata_enable edge; branch_miss_count SHALL increment when updata_enable and updata_miss are both 1.
REQ-031 Both counters SHALL saturate at 32'hFFFF_FFFF.
REQ-032 updata_miss with updata_enable=0 SHALL be ignored.
REQ-033 Lookup outputs SHALL have zero-cycle latency; all state SHALL change only on clk or rst.

Reset
REQ-034 While rst=1, all counters SHALL be 01 (weakly not-taken), GHR 0, BTB valid bits 0, branch_count 0, branch_miss_count 0.
REQ-035 Immediately after reset: predict_taken=0, BTB_hit=0, BTB_PC=0, lookup_ghr=0.
REQ-036 Reset asserted mid-update SHALL win; no partial write SHALL survive.

Verification
REQ-037 MODE=1, reset; update PC=0x100, ghr=0, taken, dest 0x200 -> lookup 0x100 with GHR=1: predict_taken=0 (index 0x40^1 still 01); BTB_hit=1, BTB_PC=0x200.
REQ-038 MODE=0: two taken updates at PC=0x40 -> predict_taken=1; three not-taken -> 0; four more not-taken -> counter holds 00.
REQ-039 Same-cycle lookup/update at PC=0x80 (taken, dest 0x300) -> BTB_hit=0 that cycle, 1 next cycle with BTB_PC=0x300.
REQ-040 PCs 0x100 and 0x100+(4<<BTB_IDX_W) both taken -> second overwrites; lookup 0x100 -> BTB_hit=0.
REQ-041 Force branch_count to 0xFFFF_FFFE via 0xFFFF_FFFE updates (or a backdoor preset), then 3 more updates -> branch_count holds 0xFFFF_FFFF; updata_miss=1 with updata_enable=0 -> branch_miss_count unchanged.
REQ-042 Assert rst asynchronously between edges after training -> all outputs return immediately to REQ-035 values.

Source files
------------

// File: rtl/gshare_bpu.sv
// gshare_bpu: gshare/bimodal direction predictor with a direct-mapped BTB.
// Lookup is purely combinational; training and history shift on clk.
module gshare_bpu #(
    parameter int BHT_IDX_W = 8,
    parameter int GHR_W     = 8,
    parameter int BTB_IDX_W = 6,
    parameter int MODE      = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   lookup_PC,
    output logic                          predict_taken,
    output logic                          BTB_hit,
    output logic [31:0]                   BTB_PC,
    output logic [((GHR_W==0)?1:GHR_W)-1:0] lookup_ghr,
    input  logic                          updata_enable,
    input  logic [31:0]                   updata_PC,
    input  logic [((GHR_W==0)?1:GHR_W)-1:0] updata_ghr,
    input  logic                          updata_taken,
    input  logic                          updata_miss,
    input  logic [31:0]                   destination_PC,
    output logic [31:0]                   branch_count,
    output logic [31:0]                   branch_miss_count
);
    localparam int GW    = (GHR_W == 0) ? 1 : GHR_W;
    localparam int BHT_N = 1 << BHT_IDX_W;
    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam int TAG_W = 32 - BTB_IDX_W - 2;

    logic [1:0]       r_bht     [BHT_N];
    logic             r_btb_vld [BTB_N];
    logic [TAG_W-1:0] r_btb_tag [BTB_N];
    logic [31:0]      r_btb_tgt [BTB_N];
    logic [GW-1:0]    r_ghr;
    logic [31:0]      r_bcnt;
    logic [31:0]      r_mcnt;

    logic [BHT_IDX_W-1:0] w_lk_mix;
    logic [BHT_IDX_W-1:0] w_up_mix;
    logic [BHT_IDX_W-1:0] w_lk_idx;
    logic [BHT_IDX_W-1:0] w_up_idx;
    logic [BTB_IDX_W-1:0] w_lk_bidx;
    logic [BTB_IDX_W-1:0] w_up_bidx;
    logic [TAG_W-1:0]     w_lk_tag;
    logic [TAG_W-1:0]     w_up_tag;
    logic [1:0]           w_cnt_old;
    logic [1:0]           w_cnt_new;
    logic                 w_btb_we;
    logic                 w_hit;
    logic                 w_unused;

    // History only folds into the index in gshare mode; the update side
    // uses the snapshot carried down the pipe, never the live register.
    assign w_lk_mix = (MODE != 0) ? BHT_IDX_W'(r_ghr) : '0;
    assign w_up_mix = (MODE != 0) ? BHT_IDX_W'(updata_ghr) : '0;
    assign w_lk_idx = lookup_PC[BHT_IDX_W+1:2] ^ w_lk_mix;
    assign w_up_idx = updata_PC[BHT_IDX_W+1:2] ^ w_up_mix;

    assign w_lk_bidx = lookup_PC[BTB_IDX_W+1:2];
    assign w_up_bidx = updata_PC[BTB_IDX_W+1:2];
    assign w_lk_tag  = lookup_PC[31:BTB_IDX_W+2];
    assign w_up_tag  = updata_PC[31:BTB_IDX_W+2];

    assign w_hit = r_btb_vld[w_lk_bidx] && (r_btb_tag[w_lk_bidx] == w_lk_tag);

    assign predict_taken     = r_bht[w_lk_idx][1];
    assign BTB_hit           = w_hit;
    assign BTB_PC            = w_hit ? r_btb_tgt[w_lk_bidx] : 32'h0;
    assign lookup_ghr        = r_ghr;
    assign branch_count      = r_bcnt;
    assign branch_miss_count = r_mcnt;

    assign w_btb_we = updata_enable && updata_taken;
    assign w_unused = ^{lookup_PC[1:0], updata_PC[1:0]};

    // Saturating 2-bit counter step for the resolving entry.
    always_comb begin
        w_cnt_old = r_bht[w_up_idx];
        w_cnt_new = w_cnt_old;
        if (updata_taken) begin
            if (w_cnt_old != 2'b11) w_cnt_new = w_cnt_old + 2'b01;
        end else begin
            if (w_cnt_old != 2'b00) w_cnt_new = w_cnt_old - 2'b01;
        end
    end

    // Pattern table: all weakly not-taken out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_N; i++) r_bht[i] <= 2'b01;
        end else if (updata_enable) begin
            r_bht[w_up_idx] <= w_cnt_new;
        end
    end

    // BTB valid bits; a taken resolution claims the slot unconditionally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_N; i++) r_btb_vld[i] <= 1'b0;
        end else if (w_btb_we) begin
            r_btb_vld[w_up_bidx] <= 1'b1;
        end
    end

    // BTB payload needs no reset; it is only observable behind valid.
    always_ff @(posedge clk) begin
        if (!rst && w_btb_we) begin
            r_btb_tag[w_up_bidx] <= w_up_tag;
            r_btb_tgt[w_up_bidx] <= destination_PC;
        end
    end

    // Global history shift register (pinned to zero when GHR_W is 0).
    generate
        if (GHR_W > 1) begin : g_ghr_n
            always_ff @(posedge clk or posedge rst) begin
                if (rst)                r_ghr <= '0;
                else if (updata_enable) r_ghr <= {r_ghr[GW-2:0], updata_taken};
            end
        end else if (GHR_W == 1) begin : g_ghr_1
            always_ff @(posedge clk or posedge rst) begin
                if (rst)                r_ghr <= '0;
                else if (updata_enable) r_ghr <= updata_taken;
            end
        end else begin : g_ghr_0
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_ghr <= '0;
                else     r_ghr <= '0;
            end
        end
    endgenerate

    // Resolved-branch and misprediction counters, saturating at all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcnt <= '0;
            r_mcnt <= '0;
        end else if (updata_enable) begin
            if (r_bcnt != 32'hFFFF_FFFF) r_bcnt <= r_bcnt + 32'd1;
            if (updata_miss && (r_mcnt != 32'hFFFF_FFFF)) r_mcnt <= r_mcnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_gshare_bpu.sv
// tb_gshare_bpu: directed vectors against a gshare and a bimodal instance
// sharing one stimulus stream; expected values are hand-derived.
module tb_gshare_bpu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] lookup_PC = 32'h0;
    logic        updata_enable = 1'b0;
    logic [31:0] updata_PC = 32'h0;
    logic [7:0]  updata_ghr = 8'h0;
    logic        updata_taken = 1'b0;
    logic        updata_miss = 1'b0;
    logic [31:0] destination_PC = 32'h0;

    logic        g_pred, b_pred;
    logic        g_hit, b_hit;
    logic [31:0] g_bpc, b_bpc;
    logic [7:0]  g_ghr, b_ghr;
    logic [31:0] g_bc, b_bc;
    logic [31:0] g_mc, b_mc;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gshare_bpu #(.MODE(1)) dut (
        .clk(clk), .rst(rst), .lookup_PC(lookup_PC),
        .predict_taken(g_pred), .BTB_hit(g_hit), .BTB_PC(g_bpc),
        .lookup_ghr(g_ghr), .updata_enable(updata_enable),
        .updata_PC(updata_PC), .updata_ghr(updata_ghr),
        .updata_taken(updata_taken), .updata_miss(updata_miss),
        .destination_PC(destination_PC),
        .branch_count(g_bc), .branch_miss_count(g_mc)
    );

    gshare_bpu #(.MODE(0)) dut0 (
        .clk(clk), .rst(rst), .lookup_PC(lookup_PC),
        .predict_taken(b_pred), .BTB_hit(b_hit), .BTB_PC(b_bpc),
        .lookup_ghr(b_ghr), .updata_enable(updata_enable),
        .updata_PC(updata_PC), .updata_ghr(updata_ghr),
        .updata_taken(updata_taken), .updata_miss(updata_miss),
        .destination_PC(destination_PC),
        .branch_count(b_bc), .branch_miss_count(b_mc)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic [7:0] gh,
                       input logic tk, input logic ms,
                       input logic [31:0] dst);
        @(negedge clk);
        updata_enable  = 1'b1;
        updata_PC      = pc;
        updata_ghr     = gh;
        updata_taken   = tk;
        updata_miss    = ms;
        destination_PC = dst;
        @(posedge clk);
        #1;
        updata_enable = 1'b0;
        updata_miss   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        lookup_PC = pc;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        lookup_PC = 32'h100;
        #2;
        chk("rst_pred", 32'(g_pred), 0);
        chk("rst_hit",  32'(g_hit), 0);
        chk("rst_bpc",  g_bpc, 0);
        chk("rst_ghr",  32'(g_ghr), 0);
        chk("rst_bc",   g_bc, 0);
        chk("rst_mc",   g_mc, 0);
        @(negedge clk);
        rst = 1'b0;

        // gshare: trained entry moved away by the new history bit
        upd(32'h100, 8'h00, 1'b1, 1'b0, 32'h200);
        look(32'h100);
        chk("gs_pred",  32'(g_pred), 0);
        chk("gs_hit",   32'(g_hit), 1);
        chk("gs_bpc",   g_bpc, 32'h200);
        chk("gs_ghr",   32'(g_ghr), 1);
        chk("gs_bc",    g_bc, 1);
        chk("bm_pred",  32'(b_pred), 1);
        look(32'h104);
        chk("gs_alias", 32'(g_pred), 1);
        chk("gs_miss",  32'(g_hit), 0);
        chk("gs_mpc",   g_bpc, 0);

        // update indexes with the carried snapshot, not live history
        do_reset();
        upd(32'h100, 8'h03, 1'b1, 1'b0, 32'h0);
        upd(32'h100, 8'h03, 1'b1, 1'b0, 32'h0);
        look(32'h100);
        chk("snap_pred", 32'(g_pred), 1);
        chk("snap_ghr",  32'(g_ghr), 3);
        upd(32'h0, 8'h00, 1'b0, 1'b0, 32'h0);
        upd(32'h0, 8'h00, 1'b1, 1'b0, 32'h0);
        chk("ghr_shift", 32'(g_ghr), 32'hD);
        chk("bm_ghr",    32'(b_ghr), 32'hD);

        // bimodal saturation at PC 0x40
        do_reset();
        look(32'h40);
        upd(32'h40, 8'h00, 1'b1, 1'b0, 32'h0);
        upd(32'h40, 8'h00, 1'b1, 1'b0, 32'h0);
        chk("sat_t2", 32'(b_pred), 1);
        upd(32'h40, 8'h00, 1'b0, 1'b0, 32'h0);
        chk("sat_n1", 32'(b_pred), 1);
        upd(32'h40, 8'h00, 1'b0, 1'b0, 32'h0);
        chk("sat_n2", 32'(b_pred), 0);
        upd(32'h40, 8'h00, 1'b0, 1'b0, 32'h0);
        chk("sat_n3", 32'(b_pred), 0);
        for (int i = 0; i < 4; i++) begin
            upd(32'h40, 8'h00, 1'b0, 1'b0, 32'h0);
            chk($sformatf("sat_hold%0d", i), 32'(b_pred), 0);
        end
        upd(32'h40, 8'h00, 1'b1, 1'b0, 32'h0);
        chk("sat_up1", 32'(b_pred), 0);
        upd(32'h40, 8'h00, 1'b1, 1'b0, 32'h0);
        chk("sat_up2", 32'(b_pred), 1);

        // same-cycle lookup and update see the old value
        do_reset();
        @(negedge clk);
        lookup_PC      = 32'h80;
        updata_enable  = 1'b1;
        updata_PC      = 32'h80;
        updata_ghr     = 8'h00;
        updata_taken   = 1'b1;
        destination_PC = 32'h300;
        #1;
        chk("byp_hit0",  32'(b_hit), 0);
        chk("byp_pred0", 32'(b_pred), 0);
        @(posedge clk);
        #1;
        updata_enable = 1'b0;
        #1;
        chk("byp_hit1",  32'(b_hit), 1);
        chk("byp_bpc1",  b_bpc, 32'h300);
        chk("byp_pred1", 32'(b_pred), 1);

        // BTB tag conflict and not-taken leaves entry alone
        do_reset();
        upd(32'h100, 8'h00, 1'b1, 1'b0, 32'h1110);
        upd(32'h200, 8'h00, 1'b1, 1'b0, 32'h2220);
        look(32'h100);
        chk("cf_hit_old", 32'(g_hit), 0);
        chk("cf_bpc_old", g_bpc, 0);
        look(32'h200);
        chk("cf_hit_new", 32'(g_hit), 1);
        chk("cf_bpc_new", g_bpc, 32'h2220);
        upd(32'h200, 8'h00, 1'b0, 1'b0, 32'h9999);
        chk("nt_keep", g_bpc, 32'h2220);

        // counters, ignored miss, saturation
        do_reset();
        upd(32'h10, 8'h00, 1'b1, 1'b1, 32'h0);
        upd(32'h10, 8'h00, 1'b0, 1'b1, 32'h0);
        upd(32'h10, 8'h00, 1'b1, 1'b0, 32'h0);
        chk("cnt_bc", g_bc, 3);
        chk("cnt_mc", g_mc, 2);
        @(negedge clk);
        updata_miss = 1'b1;
        @(posedge clk);
        #1;
        updata_miss = 1'b0;
        chk("cnt_ign_mc", g_mc, 2);
        chk("cnt_ign_bc", g_bc, 3);
        @(negedge clk);
        force dut.r_bcnt = 32'hFFFF_FFFE;
        force dut.r_mcnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_bcnt;
        release dut.r_mcnt;
        #1;
        chk("pre_bc", g_bc, 32'hFFFF_FFFE);
        upd(32'h10, 8'h00, 1'b1, 1'b1, 32'h0);
        chk("sat_bc1", g_bc, 32'hFFFF_FFFF);
        chk("sat_mc1", g_mc, 32'hFFFF_FFFF);
        upd(32'h10, 8'h00, 1'b1, 1'b1, 32'h0);
        upd(32'h10, 8'h00, 1'b1, 1'b1, 32'h0);
        chk("sat_bc3", g_bc, 32'hFFFF_FFFF);
        chk("sat_mc3", g_mc, 32'hFFFF_FFFF);

        // async reset between edges, held across an active update
        do_reset();
        upd(32'h100, 8'h00, 1'b1, 1'b1, 32'h200);
        upd(32'h100, 8'h00, 1'b1, 1'b0, 32'h200);
        look(32'h100);
        chk("tr_hit",   32'(g_hit), 1);
        chk("tr_bpred", 32'(b_pred), 1);
        @(negedge clk);
        updata_enable = 1'b1;
        updata_PC     = 32'h100;
        updata_taken  = 1'b1;
        updata_miss   = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("ar_pred",  32'(g_pred), 0);
        chk("ar_bpred", 32'(b_pred), 0);
        chk("ar_hit",   32'(g_hit), 0);
        chk("ar_bpc",   g_bpc, 0);
        chk("ar_ghr",   32'(g_ghr), 0);
        chk("ar_bc",    g_bc, 0);
        chk("ar_mc",    g_mc, 0);
        @(negedge clk);
        updata_enable = 1'b0;
        updata_miss   = 1'b0;
        rst = 1'b0;
        #1;
        chk("rw_bpred", 32'(b_pred), 0);
        chk("rw_hit",   32'(g_hit), 0);
        chk("rw_bc",    g_bc, 0);
        chk("rw_ghr",   32'(g_ghr), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
